// File: rtl/alu_writeback_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_writeback_buffer_if
//  Description : Bus bundle for the ALU writeback buffer. Carries the ALU-side
//                toggle handshake with its result fields, the regbank-side
//                toggle write port, and the CPSR/occupancy status outputs.
//  Modports    : slave  - the writeback buffer's view
//                master - the surrounding ALU/regbank environment's view
//  Signals     : readyIn/triggerOut         ALU request/ack toggles
//                dataIn1/2, addrIn1/2       result data and destinations
//                cpsrIn, wIn                new CPSR, enables {cpsr,d2,d1}
//                triggerOutW/readyInW       regbank request/ack toggles
//                addrW, dataW               regbank write address/data
//                cpsrOut, cpsrWe            CPSR copy and update pulse
//                full, empty                FIFO occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_writeback_buffer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              readyIn;
    logic              triggerOut;
    logic [DATA_W-1:0] dataIn1;
    logic [DATA_W-1:0] dataIn2;
    logic [ADDR_W-1:0] addrIn1;
    logic [ADDR_W-1:0] addrIn2;
    logic [DATA_W-1:0] cpsrIn;
    logic [2:0]        wIn;
    logic              triggerOutW;
    logic [ADDR_W-1:0] addrW;
    logic [DATA_W-1:0] dataW;
    logic              readyInW;
    logic [DATA_W-1:0] cpsrOut;
    logic              cpsrWe;
    logic              full;
    logic              empty;

    modport slave (
        input  readyIn, dataIn1, dataIn2, addrIn1, addrIn2, cpsrIn, wIn, readyInW,
        output triggerOut, triggerOutW, addrW, dataW, cpsrOut, cpsrWe, full, empty
    );

    modport master (
        output readyIn, dataIn1, dataIn2, addrIn1, addrIn2, cpsrIn, wIn, readyInW,
        input  triggerOut, triggerOutW, addrW, dataW, cpsrOut, cpsrWe, full, empty
    );
endinterface
`default_nettype wire

// File: rtl/alu_writeback_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_writeback_buffer
//  Description : Writeback stage between the ALU and the register bank.
//                ALU results arrive over a two-phase toggle handshake and are
//                queued in a DEPTH-entry FIFO. Each entry is drained as up to
//                two register writes over a second toggle handshake, followed
//                by an optional CPSR update. The ALU only sees back-pressure
//                when the FIFO is full.
//  Ports       : clk    - clock, all state on the rising edge
//                reset  - synchronous, active-high
//                bus    - alu_writeback_buffer_if.slave (ALU side, regbank
//                         side, CPSR copy and full/empty flags)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_writeback_buffer #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 4,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic               clk,
    input  wire logic               reset,
    alu_writeback_buffer_if.slave   bus
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    // Drain FSM; each write phase is split into issue and wait-for-ack.
    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_W1      = 3'd1;
    localparam logic [2:0] c_ST_W1_WAIT = 3'd2;
    localparam logic [2:0] c_ST_W2      = 3'd3;
    localparam logic [2:0] c_ST_W2_WAIT = 3'd4;
    localparam logic [2:0] c_ST_CPSR    = 3'd5;
    localparam logic [2:0] c_ST_POP     = 3'd6;

    // FIFO storage
    logic [DATA_W-1:0]  r_d1   [DEPTH];
    logic [DATA_W-1:0]  r_d2   [DEPTH];
    logic [ADDR_W-1:0]  r_a1   [DEPTH];
    logic [ADDR_W-1:0]  r_a2   [DEPTH];
    logic [DATA_W-1:0]  r_cpsr [DEPTH];
    logic [2:0]         r_w    [DEPTH];

    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               r_full;
    logic               r_empty;

    logic [SYNC_STAGES-1:0] r_rdy_sync;
    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic                   w_rdy_s;
    logic                   w_ack_s;

    logic               r_trig;
    logic               r_trig_w;
    logic [ADDR_W-1:0]  r_addr_w;
    logic [DATA_W-1:0]  r_data_w;
    logic [DATA_W-1:0]  r_cpsr_out;
    logic               r_cpsr_we;
    logic [2:0]         r_state;

    logic               w_push;
    logic               w_pop;
    logic [2:0]         w_head_w;

    // ------------------------------------------------------------------
    // Toggle synchronisers
    // ------------------------------------------------------------------
    generate
        if (SYNC_STAGES == 1) begin : g_sync_single
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_rdy_sync <= '0;
                    r_ack_sync <= '0;
                end else begin
                    r_rdy_sync <= bus.readyIn;
                    r_ack_sync <= bus.readyInW;
                end
            end
        end else begin : g_sync_chain
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_rdy_sync <= '0;
                    r_ack_sync <= '0;
                end else begin
                    r_rdy_sync <= {r_rdy_sync[SYNC_STAGES-2:0], bus.readyIn};
                    r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], bus.readyInW};
                end
            end
        end
    endgenerate

    assign w_rdy_s = r_rdy_sync[SYNC_STAGES-1];
    assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

    // A pending request is a synced toggle that has not yet been mirrored
    // back on triggerOut. Full uses the registered flag, so a slot freed by
    // a pop is only reused on a later cycle.
    assign w_push   = (w_rdy_s != r_trig) && !r_full;
    assign w_pop    = (r_state == c_ST_POP);
    assign w_head_w = r_w[r_head];

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_push && !w_pop) begin
            w_cnt_nxt = r_cnt + c_CNT_W'(1);
        end else if (w_pop && !w_push) begin
            w_cnt_nxt = r_cnt - c_CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Entry capture (storage needs no reset; validity is tracked by r_cnt)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_d1[r_tail]   <= bus.dataIn1;
            r_d2[r_tail]   <= bus.dataIn2;
            r_a1[r_tail]   <= bus.addrIn1;
            r_a2[r_tail]   <= bus.addrIn2;
            r_cpsr[r_tail] <= bus.cpsrIn;
            r_w[r_tail]    <= bus.wIn;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy, ALU ack and drain FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_cnt      <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_trig     <= 1'b0;
            r_trig_w   <= 1'b0;
            r_addr_w   <= '0;
            r_data_w   <= '0;
            r_cpsr_out <= '0;
            r_cpsr_we  <= 1'b0;
            r_state    <= c_ST_IDLE;
        end else begin
            if (w_push) begin
                r_trig <= ~r_trig;
                r_tail <= r_tail + c_PTR_W'(1);
            end

            r_cnt     <= w_cnt_nxt;
            r_full    <= (w_cnt_nxt == c_DEPTH_CNT);
            r_empty   <= (w_cnt_nxt == '0);
            r_cpsr_we <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    if (!r_empty) begin
                        r_state <= c_ST_W1;
                    end
                end
                c_ST_W1: begin
                    if (w_head_w[0]) begin
                        r_addr_w <= r_a1[r_head];
                        r_data_w <= r_d1[r_head];
                        r_trig_w <= ~r_trig_w;
                        r_state  <= c_ST_W1_WAIT;
                    end else begin
                        r_state  <= c_ST_W2;
                    end
                end
                c_ST_W1_WAIT: begin
                    if (w_ack_s == r_trig_w) begin
                        r_state <= c_ST_W2;
                    end
                end
                c_ST_W2: begin
                    if (w_head_w[1]) begin
                        r_addr_w <= r_a2[r_head];
                        r_data_w <= r_d2[r_head];
                        r_trig_w <= ~r_trig_w;
                        r_state  <= c_ST_W2_WAIT;
                    end else begin
                        r_state  <= c_ST_CPSR;
                    end
                end
                c_ST_W2_WAIT: begin
                    if (w_ack_s == r_trig_w) begin
                        r_state <= c_ST_CPSR;
                    end
                end
                c_ST_CPSR: begin
                    if (w_head_w[2]) begin
                        r_cpsr_out <= r_cpsr[r_head];
                        r_cpsr_we  <= 1'b1;
                    end
                    r_state <= c_ST_POP;
                end
                c_ST_POP: begin
                    r_head  <= r_head + c_PTR_W'(1);
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.triggerOut  = r_trig;
    assign bus.triggerOutW = r_trig_w;
    assign bus.addrW       = r_addr_w;
    assign bus.dataW       = r_data_w;
    assign bus.cpsrOut     = r_cpsr_out;
    assign bus.cpsrWe      = r_cpsr_we;
    assign bus.full        = r_full;
    assign bus.empty       = r_empty;

endmodule
`default_nettype wire

// File: tb/tb_alu_writeback_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_writeback_buffer
//  Description : Self-checking bench for alu_writeback_buffer. Drives the ALU
//                toggle handshake, models a regbank with configurable ack
//                delay, and compares writes/CPSR against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_writeback_buffer;
    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 4;
    localparam int DEPTH       = 4;
    localparam int SYNC_STAGES = 2;

    typedef struct {
        logic [2:0]        w;
        logic [ADDR_W-1:0] a1;
        logic [DATA_W-1:0] d1;
        logic [ADDR_W-1:0] a2;
        logic [DATA_W-1:0] d2;
        logic [DATA_W-1:0] cpsr;
        int                exp_writes;
        logic [ADDR_W-1:0] exp_last_a;
        logic [DATA_W-1:0] exp_last_d;
        int                exp_pulses;
        logic [DATA_W-1:0] exp_cpsr;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_writeback_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    alu_writeback_buffer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- regbank model ----------------
    bit                           ack_hold  = 1'b0;
    int                           max_delay = 0;
    int                           n_writes  = 0;
    bit                           rb_pending = 1'b0;
    logic [ADDR_W+DATA_W-1:0]     wr_q[$];
    logic [DATA_W-1:0]            regs [16];

    initial begin
        int dly;
        dly = 0;
        bus.readyInW = 1'b0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b0) begin
                bus.readyInW = 1'b0;
                rb_pending   = 1'b0;
            end else begin
                if (!rb_pending && (bus.triggerOutW != bus.readyInW)) begin
                    rb_pending = 1'b1;
                    dly = $urandom_range(0, max_delay);
                    wr_q.push_back({bus.addrW, bus.dataW});
                    regs[bus.addrW] = bus.dataW;
                    n_writes++;
                end
                if (rb_pending && !ack_hold) begin
                    if (dly == 0) begin
                        bus.readyInW = ~bus.readyInW;
                        rb_pending   = 1'b0;
                    end else begin
                        dly--;
                    end
                end
            end
        end
    end

    int n_pulses = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && bus.cpsrWe === 1'b1) n_pulses++;
        end
    end

    // ---------------- reference model ----------------
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0]        m_cpsr   = '0;
    int                       m_pulses = 0;

    function automatic void model_accept(input vec_t v);
        if (v.w[0]) exp_q.push_back({v.a1, v.d1});
        if (v.w[1]) exp_q.push_back({v.a2, v.d2});
        if (v.w[2]) begin
            m_cpsr = v.cpsr;
            m_pulses++;
        end
    endfunction

    task automatic compare_queues(input string tag);
        check({tag, "_nwrites"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            check({tag, "_write"}, wr_q[i], exp_q[i]);
        wr_q.delete();
        exp_q.delete();
    endtask

    // ---------------- ALU driver ----------------
    task automatic issue(input vec_t v);
        @(negedge clk);
        bus.wIn     = v.w;
        bus.addrIn1 = v.a1;
        bus.dataIn1 = v.d1;
        bus.addrIn2 = v.a2;
        bus.dataIn2 = v.d2;
        bus.cpsrIn  = v.cpsr;
        bus.readyIn = ~bus.readyIn;
    endtask

    task automatic wait_ack(input int budget, output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            lat++;
            if (bus.triggerOut == bus.readyIn) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.empty === 1'b1 && !rb_pending) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    function automatic vec_t rand_vec(input logic [2:0] w);
        vec_t v;
        v.w    = w;
        v.a1   = ADDR_W'($urandom_range(0, 15));
        v.a2   = ADDR_W'($urandom_range(0, 15));
        v.d1   = $urandom;
        v.d2   = $urandom;
        v.cpsr = $urandom;
        v.exp_writes = 0; v.exp_last_a = '0; v.exp_last_d = '0;
        v.exp_pulses = 0; v.exp_cpsr = '0;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tbl [6];

    initial begin
        int   lat, base_w, base_p;
        bit   ok;
        vec_t v;

        tbl[0] = '{3'b011, 4'd2, 32'hA5, 4'd7, 32'h3C, 32'hDEADBEEF, 2, 4'd7, 32'h3C, 0, 32'h0};
        tbl[1] = '{3'b100, 4'd3, 32'h11, 4'd5, 32'h22, 32'h6000_0010, 0, 4'd0, 32'h0, 1, 32'h6000_0010};
        tbl[2] = '{3'b011, 4'd4, 32'h1, 4'd4, 32'h2, 32'h0, 2, 4'd4, 32'h2, 0, 32'h6000_0010};
        tbl[3] = '{3'b000, 4'd9, 32'h99, 4'd8, 32'h88, 32'hFFFF_FFFF, 0, 4'd0, 32'h0, 0, 32'h6000_0010};
        tbl[4] = '{3'b111, 4'd1, 32'h1111_1111, 4'd15, 32'hFFFF_FFFF, 32'h0000_001F, 2, 4'd15, 32'hFFFF_FFFF, 1, 32'h0000_001F};
        tbl[5] = '{3'b001, 4'd0, 32'h1234_5678, 4'd6, 32'h0BAD_F00D, 32'h0, 1, 4'd0, 32'h1234_5678, 0, 32'h0000_001F};

        reset       = 1'b1;
        bus.readyIn = 1'b0;
        bus.wIn     = '0;
        bus.addrIn1 = '0;
        bus.addrIn2 = '0;
        bus.dataIn1 = '0;
        bus.dataIn2 = '0;
        bus.cpsrIn  = '0;
        repeat (3) @(negedge clk);
        check("rst_triggerOut",  bus.triggerOut,  0);
        check("rst_triggerOutW", bus.triggerOutW, 0);
        check("rst_addrW",       bus.addrW,       0);
        check("rst_dataW",       bus.dataW,       0);
        check("rst_cpsrOut",     bus.cpsrOut,     0);
        check("rst_cpsrWe",      bus.cpsrWe,      0);
        check("rst_full",        bus.full,        0);
        check("rst_empty",       bus.empty,       1);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // ---- directed table, one entry at a time ----
        for (int k = 0; k < 6; k++) begin
            base_w = n_writes;
            base_p = n_pulses;
            issue(tbl[k]);
            wait_ack(50, lat, ok);
            check("tbl_ack", ok, 1);
            check("tbl_latency", lat, SYNC_STAGES + 1);
            model_accept(tbl[k]);
            wait_drain(ok);
            check("tbl_drain", ok, 1);
            check("tbl_nwrites", n_writes - base_w, tbl[k].exp_writes);
            if (tbl[k].exp_writes > 0)
                check("tbl_last_write", wr_q[$], {tbl[k].exp_last_a, tbl[k].exp_last_d});
            check("tbl_cpsr_pulses", n_pulses - base_p, tbl[k].exp_pulses);
            check("tbl_cpsrOut", bus.cpsrOut, tbl[k].exp_cpsr);
            check("tbl_empty", bus.empty, 1);
        end
        check("reg4_dest2_wins", regs[4], 32'h2);
        compare_queues("tbl");

        // ---- back-pressure: regbank ack withheld, DEPTH+1 results ----
        ack_hold = 1'b1;
        max_delay = 0;
        for (int k = 0; k < DEPTH; k++) begin
            v = rand_vec(3'b011);
            issue(v);
            wait_ack(50, lat, ok);
            check("bp_ack", ok, 1);
            model_accept(v);
        end
        check("bp_full", bus.full, 1);
        check("bp_empty", bus.empty, 0);
        v = rand_vec(3'b011);
        issue(v);
        wait_ack(30, lat, ok);
        check("bp_no_ack_when_full", ok, 0);
        check("bp_still_full", bus.full, 1);
        ack_hold = 1'b0;
        wait_ack(300, lat, ok);
        check("bp_ack_after_pop", ok, 1);
        model_accept(v);
        wait_drain(ok);
        check("bp_drain", ok, 1);
        compare_queues("bp");

        // ---- randomised stream with random ack delay ----
        max_delay = 5;
        base_p = n_pulses;
        m_pulses = 0;
        for (int k = 0; k < 3 * DEPTH; k++) begin
            v = rand_vec(3'($urandom_range(0, 7)));
            issue(v);
            wait_ack(400, lat, ok);
            check("rnd_ack", ok, 1);
            model_accept(v);
        end
        wait_drain(ok);
        check("rnd_drain", ok, 1);
        compare_queues("rnd");
        check("rnd_cpsr_pulses", n_pulses - base_p, m_pulses);
        check("rnd_cpsrOut", bus.cpsrOut, m_cpsr);

        // ---- reset while the dest2 write is pending ----
        max_delay = 0;
        ack_hold  = 1'b1;
        v = rand_vec(3'b110);
        v.cpsr = 32'hCAFE_0001;
        issue(v);
        wait_ack(50, lat, ok);
        check("mid_ack", ok, 1);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rb_pending) begin
                ok = 1'b1;
                break;
            end
        end
        check("mid_w2_pending", ok, 1);
        base_w = n_writes;
        reset       = 1'b1;
        bus.readyIn = 1'b0;
        @(negedge clk);
        check("mid_rst_triggerOut",  bus.triggerOut,  0);
        check("mid_rst_triggerOutW", bus.triggerOutW, 0);
        check("mid_rst_addrW",       bus.addrW,       0);
        check("mid_rst_dataW",       bus.dataW,       0);
        check("mid_rst_cpsrOut",     bus.cpsrOut,     0);
        check("mid_rst_cpsrWe",      bus.cpsrWe,      0);
        check("mid_rst_full",        bus.full,        0);
        check("mid_rst_empty",       bus.empty,       1);
        @(negedge clk);
        reset    = 1'b0;
        ack_hold = 1'b0;
        repeat (30) @(negedge clk);
        check("mid_no_more_writes", n_writes - base_w, 0);
        check("mid_cpsr_stays_reset", bus.cpsrOut, 0);
        check("mid_empty_after", bus.empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
